// File: rtl/fib_sequence_monitor.sv
// Checks an 8-bit Fibonacci stream (0,1,1,...,MAX_TERM,0,...) against its recurrence.
// It also reports per-period length and sum, and counts sequence errors, resynchronising on its own.
module fib_sequence_monitor #(
  parameter int unsigned MAX_TERM = 233,
  parameter int unsigned EXP_LEN  = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  number,
  output logic        seq_ok,
  output logic        err_pulse,
  output logic [7:0]  err_count,
  output logic        period_done,
  output logic        len_ok,
  output logic [4:0]  last_len,
  output logic [11:0] last_sum,
  output logic [15:0] period_count
);

  typedef enum logic [1:0] {IDLE, SEED1, RUN} state_e;

  state_e      state_q, state_d;
  logic [7:0]  prev1_q, prev1_d, prev2_q, prev2_d;
  logic [4:0]  cur_len_q, cur_len_d;
  logic [11:0] cur_sum_q, cur_sum_d;
  logic        seq_ok_q, seq_ok_d, err_pulse_q, err_pulse_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        period_done_q, period_done_d, len_ok_q, len_ok_d;
  logic [4:0]  last_len_q, last_len_d;
  logic [11:0] last_sum_q, last_sum_d;
  logic [15:0] period_count_q, period_count_d;

  logic [8:0]  expected;
  logic [12:0] sum_add;
  logic [4:0]  len_inc;
  logic [11:0] sum_sat;
  logic        is_match, is_wrap, err;

  // Nine bits so that 144+233 cannot alias onto a legal 8-bit term.
  assign expected = {1'b0, prev2_q} + {1'b0, prev1_q};
  assign sum_add  = {1'b0, cur_sum_q} + {5'd0, number};
  assign sum_sat  = sum_add[12] ? 12'hFFF : sum_add[11:0];
  assign len_inc  = (cur_len_q == 5'd31) ? 5'd31 : cur_len_q + 5'd1;
  assign is_match = (expected <= 9'(MAX_TERM)) && (number == expected[7:0]);
  assign is_wrap  = (number == 8'd0) && (prev1_q == 8'(MAX_TERM));

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves a signal unassigned (no latches).
    state_d        = state_q;
    prev1_d        = prev1_q;
    prev2_d        = prev2_q;
    cur_len_d      = cur_len_q;
    cur_sum_d      = cur_sum_q;
    seq_ok_d       = seq_ok_q;
    err_count_d    = err_count_q;
    len_ok_d       = len_ok_q;
    last_len_d     = last_len_q;
    last_sum_d     = last_sum_q;
    period_count_d = period_count_q;
    err_pulse_d    = 1'b0;
    period_done_d  = 1'b0;
    err            = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          seq_ok_d = 1'b0;
          if (number == 8'd0) begin
            prev1_d   = 8'd0;
            cur_len_d = 5'd1;
            cur_sum_d = 12'd0;
            state_d   = SEED1;
          end
        end
        SEED1: begin
          seq_ok_d = 1'b0;
          if (number == 8'd1) begin
            prev2_d   = 8'd0;
            prev1_d   = 8'd1;
            cur_len_d = 5'd2;
            cur_sum_d = 12'd1;
            state_d   = RUN;
          end else begin
            err = 1'b1;
            if (number == 8'd0) begin
              prev1_d   = 8'd0;
              cur_len_d = 5'd1;
              cur_sum_d = 12'd0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        RUN: begin
          if (is_match) begin
            prev2_d   = prev1_q;
            prev1_d   = number;
            cur_len_d = len_inc;
            cur_sum_d = sum_sat;
            seq_ok_d  = 1'b1;
          end else begin
            seq_ok_d = 1'b0;
            if (is_wrap) begin
              period_done_d  = 1'b1;
              last_len_d     = cur_len_q;
              last_sum_d     = cur_sum_q;
              len_ok_d       = (cur_len_q == 5'(EXP_LEN));
              period_count_d = period_count_q + 16'd1;
            end else begin
              err = 1'b1;
            end
            // A zero always starts a new period, whether it closed one cleanly or not.
            if (number == 8'd0) begin
              prev1_d   = 8'd0;
              cur_len_d = 5'd1;
              cur_sum_d = 12'd0;
              state_d   = SEED1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (err) begin
        err_pulse_d = 1'b1;
        seq_ok_d    = 1'b0;
        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q        <= IDLE;
      prev1_q        <= '0;
      prev2_q        <= '0;
      cur_len_q      <= '0;
      cur_sum_q      <= '0;
      seq_ok_q       <= 1'b0;
      err_pulse_q    <= 1'b0;
      err_count_q    <= '0;
      period_done_q  <= 1'b0;
      len_ok_q       <= 1'b0;
      last_len_q     <= '0;
      last_sum_q     <= '0;
      period_count_q <= '0;
    end else begin
      state_q        <= state_d;
      prev1_q        <= prev1_d;
      prev2_q        <= prev2_d;
      cur_len_q      <= cur_len_d;
      cur_sum_q      <= cur_sum_d;
      seq_ok_q       <= seq_ok_d;
      err_pulse_q    <= err_pulse_d;
      err_count_q    <= err_count_d;
      period_done_q  <= period_done_d;
      len_ok_q       <= len_ok_d;
      last_len_q     <= last_len_d;
      last_sum_q     <= last_sum_d;
      period_count_q <= period_count_d;
    end
  end

  assign seq_ok       = seq_ok_q;
  assign err_pulse    = err_pulse_q;
  assign err_count    = err_count_q;
  assign period_done  = period_done_q;
  assign len_ok       = len_ok_q;
  assign last_len     = last_len_q;
  assign last_sum     = last_sum_q;
  assign period_count = period_count_q;

endmodule

// File: tb/tb_fib_sequence_monitor.sv
// Table-driven bench for fib_sequence_monitor: scenario helpers build the vector table,
// and expected outputs flow through a scoreboard queue alongside the stimulus.
module tb_fib_sequence_monitor;

  logic        clk = 1'b0;
  logic        reset, in_valid;
  logic [7:0]  number;
  logic        seq_ok, err_pulse, period_done, len_ok;
  logic [7:0]  err_count;
  logic [4:0]  last_len;
  logic [11:0] last_sum;
  logic [15:0] period_count;

  fib_sequence_monitor dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .number(number),
    .seq_ok(seq_ok), .err_pulse(err_pulse), .err_count(err_count),
    .period_done(period_done), .len_ok(len_ok), .last_len(last_len),
    .last_sum(last_sum), .period_count(period_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        seq_ok;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic        period_done;
    logic        len_ok;
    logic [4:0]  last_len;
    logic [11:0] last_sum;
    logic [15:0] period_count;
  } out_t;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] num;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  logic [7:0] fib [14] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                          8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};

  // Expected statistics as the scenario intends them to evolve.
  logic [7:0]  e_errc;
  logic [15:0] e_pc;
  logic [4:0]  e_len;
  logic [11:0] e_sum;
  logic        e_lenok;

  int n_checks = 0;
  int n_errors = 0;
  int cur_vec  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at vector %0d: got %0d, expected %0d", name, cur_vec, act, exp);
    end
  endtask

  function automatic void add(input logic valid, input logic [7:0] num,
                              input logic seq, input logic errp, input logic pd);
    vec_t v;
    if (errp && e_errc != 8'hFF) e_errc++;
    if (pd) begin
      e_pc++;
      e_len   = 5'd14;
      e_sum   = 12'd609;
      e_lenok = 1'b1;
    end
    v.rst   = 1'b0;
    v.valid = valid;
    v.num   = num;
    v.exp   = '{seq, errp, e_errc, pd, e_lenok, e_len, e_sum, e_pc};
    vecs.push_back(v);
  endfunction

  function automatic void add_reset(input logic [7:0] num);
    vec_t v;
    e_errc = '0; e_pc = '0; e_len = '0; e_sum = '0; e_lenok = 1'b0;
    v.rst   = 1'b1;
    v.valid = 1'b1;
    v.num   = num;
    v.exp   = '0;
    vecs.push_back(v);
  endfunction

  // Terms fib[lo..hi] of a clean period; seq_ok rises from the third term on.
  function automatic void terms(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) add(1'b1, fib[i], i >= 2, 1'b0, 1'b0);
  endfunction

  function automatic void close_period();
    add(1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
  endfunction

  initial begin
    out_t got, exp;
    reset = 1'b1; in_valid = 1'b0; number = '0;

    // Reset, then three clean periods
    add_reset(8'd0); add_reset(8'd0);
    add(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin terms(1, 13); close_period(); end

    // Term 6 corrupted (9 instead of 8): drop to IDLE, ignore until the next 0
    terms(1, 5);
    add(1'b1, 8'd9, 1'b0, 1'b1, 1'b0);
    for (int i = 7; i <= 13; i++) add(1'b1, fib[i], 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    terms(1, 13); close_period();

    // Generator reset mid-period: one error on the 0, then relock
    terms(1, 8);
    add(1'b1, 8'd0, 1'b0, 1'b1, 1'b0);
    terms(1, 13); close_period();

    // in_valid low for 3 cycles with garbage on number
    terms(1, 5);
    add(1'b0, 8'd77, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd255, 1'b1, 1'b0, 1'b0);
    terms(6, 13); close_period();

    // Monitor reset at term 10, stream resumes at 55
    terms(1, 9);
    add_reset(8'd55);
    add(1'b1, 8'd55, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'd89, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'd144, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    terms(1, 13); close_period();

    // Repeated 0 in SEED1: error, period restarted, still a full-length period
    add(1'b1, 8'd0, 1'b0, 1'b1, 1'b0);
    terms(1, 13); close_period();

    // Non-zero, non-one value in SEED1: error and back to IDLE
    add(1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
    add(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    terms(1, 13); close_period();

    // 144+233 overflows 8 bits to 121: must not be taken as a match
    terms(1, 13);
    add(1'b1, 8'd121, 1'b0, 1'b1, 1'b0);
    add(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);

    // Error counter saturation via repeated zeros in SEED1, then a normal period
    for (int i = 0; i < 260; i++) add(1'b1, 8'd0, 1'b0, 1'b1, 1'b0);
    terms(1, 13); close_period();

    foreach (vecs[k]) begin
      cur_vec = k;
      @(negedge clk);
      reset    = vecs[k].rst;
      in_valid = vecs[k].valid;
      number   = vecs[k].num;
      exp_q.push_back(vecs[k].exp);
      @(posedge clk);
      #1;
      got = '{seq_ok, err_pulse, err_count, period_done, len_ok, last_len, last_sum, period_count};
      exp = exp_q.pop_front();
      check("seq_ok",       32'(got.seq_ok),       32'(exp.seq_ok));
      check("err_pulse",    32'(got.err_pulse),    32'(exp.err_pulse));
      check("err_count",    32'(got.err_count),    32'(exp.err_count));
      check("period_done",  32'(got.period_done),  32'(exp.period_done));
      check("len_ok",       32'(got.len_ok),       32'(exp.len_ok));
      check("last_len",     32'(got.last_len),     32'(exp.last_len));
      check("last_sum",     32'(got.last_sum),     32'(exp.last_sum));
      check("period_count", 32'(got.period_count), 32'(exp.period_count));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fib_sequence_monitor.md
Name: fib_sequence_monitor

Overview:
- Downstream consumer of the 8-bit Fibonacci generator output stream.
- Samples `number` every valid cycle and checks the Fibonacci recurrence F(n)=F(n-1)+F(n-2) plus the wrap back to 0 after the final term.
- Reports per-period statistics (length, sum, count) and flags and counts sequence errors with automatic resynchronisation.
- Sits between the generator and the on-board status/display logic.

Parameters:
- MAX_TERM, 233: last legal term before the sequence wraps to 0.
- EXP_LEN, 14: expected number of terms per period, 0 through MAX_TERM inclusive.

Ports:
- clk  input  1  rising-edge clock, shared with the generator.
- reset  input  1  reset, synchronous, active-high.
- in_valid  input  1  number is valid this cycle; tie to 1 for a free-running generator.
- number  input  8  current generator output.
- seq_ok  output  1  high while the monitor is locked (state RUN) and no error occurred on the last sample.
- err_pulse  output  1  one-cycle pulse per detected mismatch.
- err_count  output  8  saturating mismatch count (stops at 255).
- period_done  output  1  one-cycle pulse when a complete period closes.
- len_ok  output  1  valid with period_done; 1 if last_len == EXP_LEN.
- last_len  output  5  term count of the last closed period.
- last_sum  output  12  sum of all terms of the last closed period.
- period_count  output  16  number of closed periods, wraps modulo 2^16.

Behaviour:
- All outputs are registered and update on the clk edge that samples the input, so they are visible 1 cycle after the sample.
- Reset values: all outputs 0, state IDLE, and internal prev1/prev2/cur_len/cur_sum all 0.
- A sample occurs only on edges with in_valid=1. With in_valid=0, state and statistics hold, and pulses are 0.
- Reset has priority over everything. It aborts any partial period without counting it as an error.
- States:
  - IDLE (unlocked). number==0 → prev1=0, cur_len=1, cur_sum=0, go to SEED1. Any other value is ignored: no error, stay in IDLE.
  - SEED1 (expect 1). number==1 → prev2=0, prev1=1, cur_len=2, cur_sum=1, go to RUN. number==0 → error, stay in SEED1 with period restarted at 0. Other values → error, go to IDLE.
  - RUN, expected value = prev2+prev1, computed at 9-bit width.
    - Match (number == expected and expected <= MAX_TERM): shift prev2←prev1, prev1←number, cur_len+1, cur_sum+number, seq_ok=1.
    - Wrap (number==0 and prev1==MAX_TERM): period_done=1, last_len=cur_len, last_sum=cur_sum, len_ok=(cur_len==EXP_LEN), period_count+1. Then restart the period at 0 (cur_len=1, cur_sum=0) and go to SEED1.
    - Otherwise error. If number==0, restart the period and go to SEED1; else go to IDLE. The partial period is discarded and no period_done is raised.
- Errors: any error sets err_pulse=1, seq_ok=0, and err_count+1 unless it is already 255.
- Expected value > MAX_TERM, including 9-bit overflow, is never a match. Only the wrap rule applies.
- cur_len saturates at 31. cur_sum saturates at 4095.
- Generator reset without monitor reset shows up as 0 mid-period. This is one error, then the monitor relocks within 2 samples.
- seq_ok is 0 in IDLE and SEED1.

Test Plan:
- Reset 2 cycles, then a clean stream 0,1,1,2,…,233,0: seq_ok=1 from the 3rd term onward; on the sample of the trailing 0, period_done=1, last_len=14, last_sum=609, len_ok=1, period_count=1, err_count=0.
- Three consecutive clean periods: period_count=3, three period_done pulses spaced 14 cycles apart, err_count=0.
- Corrupt term 6 (8 replaced by 9): err_pulse once, err_count=1, state goes to IDLE. No period_done until after the next 0 and a full period; the next period gives last_len=14.
- Stream reset mid-period (…,13,21,0,1,1,…): err_pulse on the 0, relock at SEED1, next period_done reports last_len=14, period_count increments only for complete periods.
- in_valid low for 3 cycles mid-sequence with number garbage: no error, statistics unchanged; the period completes normally with last_sum=609.
- Monitor reset asserted at term 10 of a period: all outputs 0 the next cycle. Stream resumes at arbitrary value 55: ignored in IDLE, no err_pulse. Lock happens on the next 0.
